// File: rtl/cpu_bus_bridge.sv
// CPU local-bus to register-file bus bridge.
// Synchronizes the asynchronous CPU strobes and turns each CPU access into exactly one
// single-cycle we/re strobe, then acknowledges the CPU with ta_n.
module cpu_bus_bridge #(
    parameter int unsigned AW         = 22,
    parameter int unsigned DW         = 32,
    parameter int unsigned ACK_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_cs_n,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_doe,
    output logic          cpu_ta_n,
    output logic [AW-1:0] addr,
    output logic          we,
    output logic          re,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data,
    output logic          err,
    output logic [7:0]    err_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StAck,
        StRelease
    } state_t;

    localparam logic [3:0] AckLast = 4'(ACK_CYCLES - 1);

    state_t     state;
    logic [3:0] ack_cnt;
    // Synchronizer output is not trustworthy until the preset value has flushed out.
    logic [1:0] settle;

    logic [1:0] cs_sync;
    logic [1:0] rd_sync;
    logic [1:0] wr_sync;
    logic       cs_s;
    logic       rd_s;
    logic       wr_s;

    // Two-flop synchronizers on the raw active-low strobes, preset inactive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync <= 2'b11;
            rd_sync <= 2'b11;
            wr_sync <= 2'b11;
        end else begin
            cs_sync <= {cs_sync[0], cpu_cs_n};
            rd_sync <= {rd_sync[0], cpu_rd_n};
            wr_sync <= {wr_sync[0], cpu_wr_n};
        end
    end

    assign cs_s = ~cs_sync[1];
    assign rd_s = ~rd_sync[1];
    assign wr_s = ~wr_sync[1];

    // Access sequencer with registered bus and CPU-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StRelease;
            settle     <= 2'd2;
            ack_cnt    <= 4'd0;
            we         <= 1'b0;
            re         <= 1'b0;
            cpu_ta_n   <= 1'b1;
            cpu_doe    <= 1'b0;
            cpu_dout   <= '0;
            addr       <= '0;
            write_data <= '0;
            err        <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cs_s && wr_s && !rd_s) begin
                        addr       <= cpu_addr;
                        write_data <= cpu_din;
                        we         <= 1'b1;
                        state      <= StWrite;
                    end else if (cs_s && rd_s && !wr_s) begin
                        addr  <= cpu_addr;
                        re    <= 1'b1;
                        state <= StRead;
                    end else if (cs_s && rd_s && wr_s) begin
                        err <= 1'b1;
                        if (err_cnt != 8'hff) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state <= StRelease;
                    end
                end
                StWrite: begin
                    we       <= 1'b0;
                    cpu_ta_n <= 1'b0;
                    ack_cnt  <= AckLast;
                    state    <= StAck;
                end
                StRead: begin
                    // read_data is combinational from re/addr, so it is valid at this edge.
                    re       <= 1'b0;
                    cpu_dout <= read_data;
                    cpu_doe  <= 1'b1;
                    cpu_ta_n <= 1'b0;
                    ack_cnt  <= AckLast;
                    state    <= StAck;
                end
                StAck: begin
                    if (ack_cnt == 4'd0) begin
                        cpu_ta_n <= 1'b1;
                        state    <= StRelease;
                    end else begin
                        ack_cnt <= ack_cnt - 4'd1;
                    end
                end
                StRelease: begin
                    cpu_ta_n <= 1'b1;
                    if (settle != 2'd0) begin
                        settle <= settle - 2'd1;
                    end else if (!cs_s) begin
                        cpu_doe <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StRelease;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench for cpu_bus_bridge: scoreboard of expected bus strobes.
module tb_cpu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_cs_n, cpu_rd_n, cpu_wr_n;
    logic [21:0] cpu_addr;
    logic [31:0] cpu_din, cpu_dout;
    logic        cpu_doe, cpu_ta_n;
    logic [21:0] addr;
    logic        we, re, err;
    logic [31:0] write_data, read_data;
    logic [7:0]  err_cnt;
    logic [31:0] rd_val;

    // Second instance built with a one-cycle acknowledge.
    logic        cs2_n, rd2_n, wr2_n;
    logic [21:0] cpu_addr2, addr2;
    logic [31:0] cpu_din2, cpu_dout2, write_data2, read_data2;
    logic        doe2, ta2_n, we2, re2, err2;
    logic [7:0]  err_cnt2;

    always #5 clk = ~clk;

    assign read_data  = re ? rd_val : 32'hDEAD;
    assign read_data2 = re2 ? (32'hC0DE_0000 | {10'b0, addr2}) : 32'hDEAD;

    cpu_bus_bridge dut (
        .clk(clk), .rst_n(rst_n), .cpu_cs_n(cpu_cs_n), .cpu_rd_n(cpu_rd_n),
        .cpu_wr_n(cpu_wr_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_doe(cpu_doe), .cpu_ta_n(cpu_ta_n), .addr(addr), .we(we), .re(re),
        .write_data(write_data), .read_data(read_data), .err(err), .err_cnt(err_cnt)
    );

    cpu_bus_bridge #(.ACK_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cpu_cs_n(cs2_n), .cpu_rd_n(rd2_n),
        .cpu_wr_n(wr2_n), .cpu_addr(cpu_addr2), .cpu_din(cpu_din2), .cpu_dout(cpu_dout2),
        .cpu_doe(doe2), .cpu_ta_n(ta2_n), .addr(addr2), .we(we2), .re(re2),
        .write_data(write_data2), .read_data(read_data2), .err(err2), .err_cnt(err_cnt2)
    );

    typedef struct {
        bit          is_wr;
        logic [21:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0, re_cnt = 0, ta_cnt = 0, err_pulses = 0;

    // Monitor: every bus strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we && re) begin
                n_cmp++; n_bad++;
                $display("FAIL we_re_overlap: we=%b re=%b, required never both", we, re);
            end
            if (we || re) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_strobe: we=%b re=%b addr=%h, required none",
                             we, re, addr);
                end else begin
                    txn_t e;
                    e = sb.pop_front();
                    if (we !== e.is_wr || addr !== e.a || (e.is_wr && write_data !== e.d)) begin
                        n_bad++;
                        $display("FAIL bus_txn: we=%b addr=%h wd=%h, required we=%b addr=%h wd=%h",
                                 we, addr, write_data, e.is_wr, e.a, e.d);
                    end
                end
            end
            if (we) we_cnt++;
            if (re) re_cnt++;
            if (!cpu_ta_n) ta_cnt++;
            if (err) err_pulses++;
        end
    end

    task automatic idle_pins();
        cpu_cs_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    endtask

    // Drive one CPU access and hold it for 'hold' cycles; return activity deltas.
    task automatic run_access(input logic rd_l, input logic wr_l, input logic [21:0] a,
                              input logic [31:0] d, input int hold,
                              output int dwe, output int dre, output int dta, output int derr);
        int w0, r0, t0, e0;
        w0 = we_cnt; r0 = re_cnt; t0 = ta_cnt; e0 = err_pulses;
        @(negedge clk);
        cpu_addr = a; cpu_din = d; cpu_cs_n = 1'b0; cpu_rd_n = rd_l; cpu_wr_n = wr_l;
        repeat (hold) @(negedge clk);
        dwe = we_cnt - w0; dre = re_cnt - r0; dta = ta_cnt - t0; derr = err_pulses - e0;
    endtask

    // Deassert the CPU pins and keep them high for the minimum 3 cycles.
    task automatic release_cs();
        idle_pins();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({we, re, cpu_ta_n, cpu_doe, err} !== 5'b00100 || cpu_dout !== 32'h0 ||
            addr !== 22'h0 || write_data !== 32'h0 || err_cnt !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_state: we=%b re=%b ta_n=%b doe=%b dout=%h addr=%h wd=%h err=%b cnt=%0d, required 0 0 1 0 0 0 0 0 0",
                     we, re, cpu_ta_n, cpu_doe, cpu_dout, addr, write_data, err, err_cnt);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        int dwe, dre, dta, derr;
        sb.push_back('{1'b1, 22'h0003, 32'h0000_00A5});
        run_access(1'b1, 1'b0, 22'h0003, 32'h0000_00A5, 20, dwe, dre, dta, derr);
        n_cmp++;
        if (dwe != 1 || dre != 0) begin
            n_bad++;
            $display("FAIL write_pulses: we=%0d re=%0d, required 1 0", dwe, dre);
        end
        n_cmp++;
        if (dta != 2) begin
            n_bad++;
            $display("FAIL write_ta_len: got %0d, required 2", dta);
        end
        release_cs();
    endtask

    task automatic test_read();
        int dwe, dre, dta, derr;
        rd_val = 32'h0000_005A;
        sb.push_back('{1'b0, 22'h0004, 32'h0});
        run_access(1'b0, 1'b1, 22'h0004, 32'h0, 20, dwe, dre, dta, derr);
        n_cmp++;
        if (dre != 1 || dwe != 0) begin
            n_bad++;
            $display("FAIL read_pulses: re=%0d we=%0d, required 1 0", dre, dwe);
        end
        n_cmp++;
        if (cpu_dout !== 32'h5A || cpu_doe !== 1'b1) begin
            n_bad++;
            $display("FAIL read_data: dout=%h doe=%b, required 0000005a 1", cpu_dout, cpu_doe);
        end
        n_cmp++;
        if (dta != 2) begin
            n_bad++;
            $display("FAIL read_ta_len: got %0d, required 2", dta);
        end
        idle_pins();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (cpu_doe !== 1'b1) begin
            n_bad++;
            $display("FAIL read_doe_hold: doe=%b, required 1", cpu_doe);
        end
        @(negedge clk);
        n_cmp++;
        if (cpu_doe !== 1'b0) begin
            n_bad++;
            $display("FAIL read_doe_off: doe=%b, required 0", cpu_doe);
        end
    endtask

    task automatic test_back_to_back();
        int dwe, dre, dta, derr, w0;
        w0 = we_cnt;
        sb.push_back('{1'b1, 22'h0008, 32'h11});
        sb.push_back('{1'b1, 22'h000D, 32'h22});
        run_access(1'b1, 1'b0, 22'h0008, 32'h11, 10, dwe, dre, dta, derr);
        release_cs();
        run_access(1'b1, 1'b0, 22'h000D, 32'h22, 10, dwe, dre, dta, derr);
        release_cs();
        n_cmp++;
        if (we_cnt - w0 != 2 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_count: we=%0d pending=%0d, required 2 0", we_cnt - w0, sb.size());
        end
    endtask

    task automatic test_illegal();
        int dwe, dre, dta, derr;
        run_access(1'b0, 1'b0, 22'h0005, 32'h0, 8, dwe, dre, dta, derr);
        n_cmp++;
        if (dwe != 0 || dre != 0 || dta != 0 || derr != 1 || err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL illegal_once: we=%0d re=%0d ta=%0d err=%0d cnt=%0d, required 0 0 0 1 1",
                     dwe, dre, dta, derr, err_cnt);
        end
        release_cs();
        for (int i = 1; i < 300; i++) begin
            run_access(1'b0, 1'b0, 22'h0005, 32'h0, 6, dwe, dre, dta, derr);
            release_cs();
        end
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL illegal_saturate: cnt=%0d, required 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid_access();
        int dwe, dre, dta, derr, w0;
        bit seen;
        sb.push_back('{1'b1, 22'h0020, 32'h33});
        @(negedge clk);
        cpu_addr = 22'h0020; cpu_din = 32'h33; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (!cpu_ta_n) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL rst_mid_ack_seen: ta_n never low, required low within 12 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({we, re, cpu_ta_n, cpu_doe, err} !== 5'b00100 || addr !== 22'h0 ||
            write_data !== 32'h0 || err_cnt !== 8'h0 || cpu_dout !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid_state: we=%b re=%b ta_n=%b doe=%b err=%b addr=%h wd=%h cnt=%0d, required reset values",
                     we, re, cpu_ta_n, cpu_doe, err, addr, write_data, err_cnt);
        end
        rst_n = 1'b1;
        w0 = we_cnt;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (we_cnt != w0 || cpu_ta_n !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_no_replay: we=%0d ta_n=%b, required 0 1", we_cnt - w0, cpu_ta_n);
        end
        release_cs();
        sb.push_back('{1'b1, 22'h0021, 32'h44});
        run_access(1'b1, 1'b0, 22'h0021, 32'h44, 12, dwe, dre, dta, derr);
        n_cmp++;
        if (dwe != 1 || dta != 2 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL rst_fresh_access: we=%0d ta=%0d pending=%0d, required 1 2 0",
                     dwe, dta, sb.size());
        end
        release_cs();
    endtask

    task automatic test_ack1();
        int nta, nre, nwe;
        nta = 0; nre = 0; nwe = 0;
        @(negedge clk);
        cpu_addr2 = 22'h1000; cs2_n = 1'b0; rd2_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ta2_n) nta++;
            if (re2) nre++;
            if (we2) nwe++;
        end
        n_cmp++;
        if (nta != 1 || nre != 1 || nwe != 0) begin
            n_bad++;
            $display("FAIL ack1_timing: ta=%0d re=%0d we=%0d, required 1 1 0", nta, nre, nwe);
        end
        n_cmp++;
        if (cpu_dout2 !== 32'hC0DE_1000) begin
            n_bad++;
            $display("FAIL ack1_data: dout=%h, required c0de1000", cpu_dout2);
        end
        cs2_n = 1'b1; rd2_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        idle_pins();
        cpu_addr = '0; cpu_din = '0; rd_val = 32'h0;
        cs2_n = 1'b1; rd2_n = 1'b1; wr2_n = 1'b1; cpu_addr2 = '0; cpu_din2 = '0;
        rst_n = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_illegal();
        test_reset_mid_access();
        test_ack1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Bus initiator that drives the internal register-file bus (addr/we/re/write_data/read_data) from the external asynchronous CPU local bus (chip select, read/write strobes, 22-bit word address with A30/A31 dropped, 32-bit data).
- Synchronizes the CPU strobes and turns each CPU access into exactly one single-cycle we or re strobe.
- Captures the read data and returns a transfer-acknowledge to the CPU.
- Sits between the FPGA pins and the UART/NAND register block.

Parameters:
- AW, 22, internal word-address width.
- DW, 32, data width.
- ACK_CYCLES, 2, number of clk cycles ta_n is held low (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_cs_n  in  1  async chip select, active-low.
- cpu_rd_n  in  1  async read strobe, active-low.
- cpu_wr_n  in  1  async write strobe, active-low.
- cpu_addr  in  AW  CPU word address; stable from strobe low until cs_n high.
- cpu_din  in  DW  CPU write data; stable like cpu_addr.
- cpu_dout  out  DW  read data returned to CPU.
- cpu_doe  out  1  output enable for the data pad tri-state.
- cpu_ta_n  out  1  transfer acknowledge, active-low.
- addr  out  AW  register-bus address.
- we  out  1  register-bus write strobe.
- re  out  1  register-bus read strobe.
- write_data  out  DW  register-bus write data.
- read_data  in  DW  register-bus read data; combinational from re and addr.
- err  out  1  protocol-error pulse.
- err_cnt  out  8  saturating protocol-error count.

Behaviour:
- Reset (rst_n low at a clk edge): we=0, re=0, cpu_ta_n=1, cpu_doe=0, cpu_dout=0, addr=0, write_data=0, err=0, err_cnt=0. Synchronizer flops are preset to 1 (inactive). FSM goes to RELEASE, not IDLE, so a CPU access already in progress at reset is never executed.
- Synchronizers: cpu_cs_n, cpu_rd_n and cpu_wr_n each pass through a 2-flop chain giving cs_s, rd_s, wr_s. cpu_addr and cpu_din are not synchronized; they are latched only when the FSM leaves IDLE.
- IDLE:
  - cs_s & wr_s & !rd_s: latch addr<=cpu_addr, write_data<=cpu_din; go to WRITE.
  - cs_s & rd_s & !wr_s: latch addr; go to READ.
  - cs_s & rd_s & wr_s: no strobe; err=1 for one cycle; err_cnt+1, saturating at 255; go to RELEASE with no ack.
  - Otherwise stay in IDLE.
- WRITE: we=1 for exactly one cycle; go to ACK.
- READ:
  - re=1 for exactly one cycle.
  - cpu_dout<=read_data is captured at the same edge that ends the cycle.
  - cpu_doe=1 from the next cycle onward.
  - Go to ACK.
  - re is never held longer than one cycle, so rx_read/sr_read side effects happen exactly once per CPU access.
- ACK: cpu_ta_n=0 for ACK_CYCLES cycles (4-bit counter); then go to RELEASE.
- RELEASE:
  - cpu_ta_n=1.
  - cpu_doe stays 1 (reads) until !cs_s, then cpu_doe=0 and go to IDLE.
  - A strobe change while cs_s is still asserted is ignored; no second access.
- Latency: strobe low at pin → latched at edge 3 (IDLE exit) → we/re high during cycle 4 → ta_n low from edge 4 for ACK_CYCLES cycles.
- Minimum cs_n high time between accesses: 3 clk.
- addr and write_data hold their last value between accesses.
- we and re are never high together.

Test Plan:
- Write: cs_n/wr_n low, cpu_addr=22'h0003, cpu_din=32'h000000A5, held 20 clk → exactly one we pulse with addr=0x0003, write_data=0xA5; ta_n low exactly 2 cycles; re never high.
- Read: cs_n/rd_n low, addr=22'h0004; bench read_data model returns 0x5A only while re=1 (else 0xDEAD) → exactly one re pulse; cpu_dout=0x5A; cpu_doe high until 2 clk after cs_n rises.
- Illegal: rd_n and wr_n both low with cs_n → no we/re; ta_n stays 1; err pulse; err_cnt=1. Repeat 300 times → err_cnt=255.
- Back-to-back: two writes (0x0008/0x11, 0x000D/0x22) with cs_n high 3 clk between → two we pulses in order with matching addr/data.
- Reset mid-access: rst_n low during ACK with cs_n still low, then released → all outputs at reset values; no strobe until cs_n goes high and a fresh access starts, which then completes normally.
- ACK_CYCLES=1 build: read of 22'h1000 → ta_n low exactly 1 cycle; ram data returned.
